traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_pkg.sv | 48 ++++
 rtl/phase_timer.sv | 45 ++++
 rtl/traffic_phase_scheduler.sv | 138 +++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp patterns for the two-road phase scheduler.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package traffic_pkg;

  // Encodings 6 and 7 are illegal and are recovered to ALLRED_A by the scheduler.
  typedef enum logic [2:0] {
    ALLRED_A = 3'd0,
    GREEN1   = 3'd1,
    YELLOW1  = 3'd2,
    ALLRED_B = 3'd3,
    GREEN2   = 3'd4,
    YELLOW2  = 3'd5
  } state_t;

  typedef struct packed {
    logic red1;
    logic yellow1;
    logic green1;
    logic red2;
    logic yellow2;
    logic green2;
  } lamps_t;

  localparam lamps_t LAMPS_ALLRED  = lamps_t'(6'b100_100);
  localparam lamps_t LAMPS_GREEN1  = lamps_t'(6'b001_100);
  localparam lamps_t LAMPS_YELLOW1 = lamps_t'(6'b010_100);
  localparam lamps_t LAMPS_GREEN2  = lamps_t'(6'b100_001);
  localparam lamps_t LAMPS_YELLOW2 = lamps_t'(6'b100_010);

  // Any unknown encoding lights both reds, which is the safe display.
  function automatic lamps_t lamp_decode(input state_t s);
    case (s)
      GREEN1:  return LAMPS_GREEN1;
      YELLOW1: return LAMPS_YELLOW1;
      GREEN2:  return LAMPS_GREEN2;
      YELLOW2: return LAMPS_YELLOW2;
      default: return LAMPS_ALLRED;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase prescaler plus saturating seconds counter.
// Latency: tick/done are combinational from the counters; counters update each clk.
// Backpressure: none; clear restarts the phase from zero on the next edge.
//
// Ports: clk, rst (async, active-high), clear (restart both counters),
//        limit (phase length in seconds, seconds saturate here),
//        tick (last cycle of a second), sec (completed seconds),
//        done (last cycle of the limit-th second, or any later second boundary).
module phase_timer #(
  parameter int CLK_HZ = 50_000_000,
  parameter int SEC_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [SEC_W-1:0] limit,
  output logic             tick,
  output logic [SEC_W-1:0] sec,
  output logic             done
);

  localparam int CNT_W = $clog2(CLK_HZ + 1);

  logic [CNT_W-1:0] presc;

  assign tick = (presc == CNT_W'(CLK_HZ - 1));
  // ">=" so a saturated green keeps reporting done on every later boundary.
  assign done = tick && (sec >= (limit - SEC_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      sec   <= '0;
    end else if (clear) begin
      presc <= '0;
      sec   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick && (sec < limit)) begin
        sec <= sec + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic light sequencer with demand-actuated greens and pedestrian walk.
// Latency: lamps/walks are registered decodes of next_state, changing with the state.
// Backpressure: none; detector/button requests are latched until their green is served.
//
// Ports: clk, rst (async, active-high), veh1/veh2 (vehicle detectors),
//        ped1/ped2 (pedestrian buttons), red/yellow/green 1 and 2 (lamp drives),
//        walk1/walk2 (pedestrian walk lamps).
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GREEN_MIN_S = 10,
  parameter int YELLOW_S    = 5,
  parameter int ALLRED_S    = 2,
  parameter int WALK_S      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic veh1,
  input  logic veh2,
  input  logic ped1,
  input  logic ped2,
  output logic red1,
  output logic yellow1,
  output logic green1,
  output logic red2,
  output logic yellow2,
  output logic green2,
  output logic walk1,
  output logic walk2
);

  localparam int SEC_W = $clog2(max3(GREEN_MIN_S, YELLOW_S, ALLRED_S) + 1);

  state_t           state;
  state_t           next_state;
  logic [SEC_W-1:0] limit;
  logic [SEC_W-1:0] sec;
  logic             tick;
  logic             done;
  logic             phase_change;
  logic             enter_g1, enter_g2;
  logic             stay_g1, stay_g2;
  logic             walk_open;
  logic             dem1, dem2;
  logic             pend1, pend2;
  logic             serve1, serve2;

  always_comb begin
    limit = SEC_W'(ALLRED_S);
    case (state)
      GREEN1, GREEN2:   limit = SEC_W'(GREEN_MIN_S);
      YELLOW1, YELLOW2: limit = SEC_W'(YELLOW_S);
      default:          limit = SEC_W'(ALLRED_S);
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      ALLRED_A: if (done)         next_state = GREEN1;
      GREEN1:   if (done && dem2) next_state = YELLOW1;
      YELLOW1:  if (done)         next_state = ALLRED_B;
      ALLRED_B: if (done)         next_state = GREEN2;
      GREEN2:   if (done && dem1) next_state = YELLOW2;
      YELLOW2:  if (done)         next_state = ALLRED_A;
      default:                    next_state = ALLRED_A;
    endcase
  end

  assign phase_change = (next_state != state);
  assign enter_g1     = (next_state == GREEN1) && (state != GREEN1);
  assign enter_g2     = (next_state == GREEN2) && (state != GREEN2);
  assign stay_g1      = (next_state == GREEN1) && (state == GREEN1);
  assign stay_g2      = (next_state == GREEN2) && (state == GREEN2);

  // True when the cycle after this edge still falls inside the first WALK_S seconds.
  assign walk_open = tick ? (sec < SEC_W'(WALK_S - 1)) : (sec < SEC_W'(WALK_S));

  phase_timer #(
    .CLK_HZ (CLK_HZ),
    .SEC_W  (SEC_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (phase_change),
    .limit (limit),
    .tick  (tick),
    .sec   (sec),
    .done  (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ALLRED_A;
      {red1, yellow1, green1, red2, yellow2, green2} <= LAMPS_ALLRED;
      walk1  <= 1'b0;
      walk2  <= 1'b0;
      dem1   <= 1'b0;
      dem2   <= 1'b0;
      pend1  <= 1'b0;
      pend2  <= 1'b0;
      serve1 <= 1'b0;
      serve2 <= 1'b0;
    end else begin
      state <= next_state;
      {red1, yellow1, green1, red2, yellow2, green2} <= lamp_decode(next_state);

      // Entry to a green wins over a same-cycle request: that road is being served now.
      if (enter_g1) begin
        dem1   <= 1'b0;
        pend1  <= 1'b0;
        serve1 <= pend1;
      end else begin
        if (ped1 || (veh1 && (state != GREEN1))) dem1  <= 1'b1;
        if (ped1 && (state != GREEN1))           pend1 <= 1'b1;
      end

      if (enter_g2) begin
        dem2   <= 1'b0;
        pend2  <= 1'b0;
        serve2 <= pend2;
      end else begin
        if (ped2 || (veh2 && (state != GREEN2))) dem2  <= 1'b1;
        if (ped2 && (state != GREEN2))           pend2 <= 1'b1;
      end

      if (enter_g1)     walk1 <= pend1;
      else if (stay_g1) walk1 <= serve1 && walk_open;
      else              walk1 <= 1'b0;

      if (enter_g2)     walk2 <= pend2;
      else if (stay_g2) walk2 <= serve2 && walk_open;
      else              walk2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler with a 10-cycle second.
// Latency: n/a.
// Backpressure: n/a.
module tb_traffic_phase_scheduler;

  localparam int CLK_HZ = 10;
  localparam int GMIN   = 3;
  localparam int YEL    = 2;
  localparam int AR     = 1;
  localparam int WALK   = 2;

  // Observed pattern: {red1,yellow1,green1,red2,yellow2,green2,walk1,walk2}
  localparam logic [7:0] P_AR  = 8'h90;
  localparam logic [7:0] P_G1  = 8'h30;
  localparam logic [7:0] P_G1W = 8'h32;
  localparam logic [7:0] P_Y1  = 8'h50;
  localparam logic [7:0] P_G2  = 8'h84;
  localparam logic [7:0] P_Y2  = 8'h88;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic veh1 = 1'b0;
  logic veh2 = 1'b0;
  logic ped1 = 1'b0;
  logic ped2 = 1'b0;
  logic red1, yellow1, green1, red2, yellow2, green2, walk1, walk2;
  logic [7:0] obs;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .CLK_HZ      (CLK_HZ),
    .GREEN_MIN_S (GMIN),
    .YELLOW_S    (YEL),
    .ALLRED_S    (AR),
    .WALK_S      (WALK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .veh1    (veh1),
    .veh2    (veh2),
    .ped1    (ped1),
    .ped2    (ped2),
    .red1    (red1),
    .yellow1 (yellow1),
    .green1  (green1),
    .red2    (red2),
    .yellow2 (yellow2),
    .green2  (green2),
    .walk1   (walk1),
    .walk2   (walk2)
  );

  assign obs = {red1, yellow1, green1, red2, yellow2, green2, walk1, walk2};

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Safety invariants, sampled every falling edge for the whole run.
  always @(negedge clk) begin
    logic ok;
    ok = ($countones({red1, yellow1, green1}) == 1) &&
         ($countones({red2, yellow2, green2}) == 1) &&
         (red1 || red2) &&
         (!walk1 || green1) && (!walk2 || green2);
    checks++;
    if (ok) passes++;
    else $display("FAIL lamp_invariant: lamps/walks=%b, expected one lamp per road, a red somewhere, walk only on own green", obs);
  end

  // ---------------- reference model: phase index + cycles spent in phase ----------------
  // phases: 0 ALLRED_A, 1 GREEN1, 2 YELLOW1, 3 ALLRED_B, 4 GREEN2, 5 YELLOW2
  int mp;
  int mcyc;
  bit mdem[2];
  bit mpend[2];
  bit mserve[2];

  task automatic model_reset();
    mp = 0;
    mcyc = 0;
    for (int r = 0; r < 2; r++) begin
      mdem[r] = 0; mpend[r] = 0; mserve[r] = 0;
    end
  endtask

  task automatic model_step(input bit v1, input bit v2, input bit p1, input bit p2);
    int np;
    bit veh[2];
    bit ped[2];
    int g;
    veh[0] = v1; veh[1] = v2; ped[0] = p1; ped[1] = p2;
    np = mp;
    case (mp)
      0, 3: if (mcyc + 1 == AR * CLK_HZ) np = mp + 1;
      2, 5: if (mcyc + 1 == YEL * CLK_HZ) np = (mp + 1) % 6;
      1: if (((mcyc + 1) % CLK_HZ == 0) && (mcyc + 1 >= GMIN * CLK_HZ) && mdem[1]) np = 2;
      4: if (((mcyc + 1) % CLK_HZ == 0) && (mcyc + 1 >= GMIN * CLK_HZ) && mdem[0]) np = 5;
      default: np = 0;
    endcase
    for (int r = 0; r < 2; r++) begin
      g = (r == 0) ? 1 : 4;
      if (np == g && mp != g) begin
        mdem[r] = 0;
        mserve[r] = mpend[r];
        mpend[r] = 0;
      end else begin
        if (ped[r] || (veh[r] && mp != g)) mdem[r] = 1;
        if (ped[r] && mp != g) mpend[r] = 1;
      end
    end
    mcyc = (np == mp) ? mcyc + 1 : 0;
    mp = np;
  endtask

  function automatic logic [7:0] model_exp();
    return {mp != 1 && mp != 2, mp == 2, mp == 1,
            mp != 4 && mp != 5, mp == 5, mp == 4,
            mp == 1 && mserve[0] && mcyc < WALK * CLK_HZ,
            mp == 4 && mserve[1] && mcyc < WALK * CLK_HZ};
  endfunction

  task automatic wait_for(input string name, input logic [7:0] exp, input int budget);
    int k;
    k = 0;
    while (obs !== exp && k < budget) begin
      @(negedge clk);
      k++;
    end
    check8(name, obs, exp);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         r;
    bit         v1;
    bit         v2;
    bit         p1;
    bit         p2;
    int         n;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: still running at t=%0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset release, nobody waiting: 10 cycles all-red then green1 rests
    tbl[0]  = '{1, 0, 0, 0, 0,   2, P_AR};
    tbl[1]  = '{0, 0, 0, 0, 0,   9, P_AR};
    tbl[2]  = '{0, 0, 0, 0, 0,   1, P_G1};
    tbl[3]  = '{0, 0, 0, 0, 0, 200, P_G1};
    // veh2 pulse 5 cycles into green1: green 30, yellow 20, all-red 10
    tbl[4]  = '{1, 0, 0, 0, 0,   1, P_AR};
    tbl[5]  = '{0, 0, 0, 0, 0,  10, P_G1};
    tbl[6]  = '{0, 0, 0, 0, 0,   5, P_G1};
    tbl[7]  = '{0, 0, 1, 0, 0,   1, P_G1};
    tbl[8]  = '{0, 0, 0, 0, 0,  23, P_G1};
    tbl[9]  = '{0, 0, 0, 0, 0,   1, P_Y1};
    tbl[10] = '{0, 0, 0, 0, 0,  19, P_Y1};
    tbl[11] = '{0, 0, 0, 0, 0,   1, P_AR};
    tbl[12] = '{0, 0, 0, 0, 0,   9, P_AR};
    tbl[13] = '{0, 0, 0, 0, 0,   1, P_G2};
    // ped1 during green2: back to green1 after min green, walk1 for first 20 cycles
    tbl[14] = '{0, 0, 0, 1, 0,   1, P_G2};
    tbl[15] = '{0, 0, 0, 0, 0,  28, P_G2};
    tbl[16] = '{0, 0, 0, 0, 0,   1, P_Y2};
    tbl[17] = '{0, 0, 0, 0, 0,  19, P_Y2};
    tbl[18] = '{0, 0, 0, 0, 0,   1, P_AR};
    tbl[19] = '{0, 0, 0, 0, 0,   9, P_AR};
    tbl[20] = '{0, 0, 0, 0, 0,   1, P_G1W};
    tbl[21] = '{0, 0, 0, 0, 0,  19, P_G1W};
    tbl[22] = '{0, 0, 0, 0, 0,   1, P_G1};
    // veh1 held on its own green: nothing changes
    tbl[23] = '{0, 1, 0, 0, 0, 100, P_G1};

    #1 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      rst  = tbl[i].r;
      veh1 = tbl[i].v1;
      veh2 = tbl[i].v2;
      ped1 = tbl[i].p1;
      ped2 = tbl[i].p2;
      repeat (tbl[i].n) @(posedge clk);
      @(negedge clk);
      check8($sformatf("vec%0d", i), obs, tbl[i].exp);
    end
    check8("dem1_ignored_on_own_green", {7'b0, dut.dem1}, 8'h00);

    // reset in the middle of yellow2
    veh1 = 1'b0;
    veh2 = 1'b1;
    @(negedge clk);
    veh2 = 1'b0;
    wait_for("reach_green2", P_G2, 200);
    veh1 = 1'b1;
    @(negedge clk);
    veh1 = 1'b0;
    wait_for("reach_yellow2", P_Y2, 200);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check8("rst_async_allred", obs, P_AR);
    check8("rst_clears_dem1", {7'b0, dut.dem1}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check8("rst_full_allred", obs, P_AR);
    @(negedge clk);
    check8("rst_then_green1", obs, P_G1);

    // randomized traffic against the reference model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      check8($sformatf("rand_c%0d", c), obs, model_exp());
      veh1 = ($urandom_range(0, 29) == 0);
      veh2 = ($urandom_range(0, 29) == 0);
      ped1 = ($urandom_range(0, 59) == 0);
      ped2 = ($urandom_range(0, 59) == 0);
      model_step(veh1, veh2, ped1, ped2);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
